// File: rtl/counter_result_checker.sv
// Cycle-exact result comparator for the 4-bit counter environment: compares DUT and
// scoreboard streams over a fixed window and reports pass/fail, error count and first failure.
module counter_result_checker #(
  parameter int ITERATIONS = 100,
  parameter int ERRW       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      dut_Q,
  input  logic            dut_load,
  input  logic            dut_rco,
  input  logic [3:0]      scb_Q,
  input  logic            scb_load,
  input  logic            scb_rco,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            mismatch,
  output logic [2:0]      mismatch_mask,
  output logic [ERRW-1:0] err_count,
  output logic [15:0]     sample_count,
  output logic [15:0]     first_err_idx,
  output logic [5:0]      first_err_dut,
  output logic [5:0]      first_err_scb
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(ITERATIONS - 1);
  localparam logic [15:0] NO_ERR   = 16'hFFFF;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            mismatch_q, mismatch_d;
  logic [2:0]      mask_q, mask_d;
  logic [ERRW-1:0] err_count_q, err_count_d;
  logic [15:0]     sample_count_q, sample_count_d;
  logic [15:0]     first_idx_q, first_idx_d;
  logic [5:0]      first_dut_q, first_dut_d;
  logic [5:0]      first_scb_q, first_scb_d;
  logic [2:0]      diff;

  assign diff = {dut_rco != scb_rco, dut_load != scb_load, dut_Q != scb_Q};

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    done_d         = done_q;
    pass_d         = pass_q;
    mismatch_d     = mismatch_q;
    mask_d         = mask_q;
    err_count_d    = err_count_q;
    sample_count_d = sample_count_q;
    first_idx_d    = first_idx_q;
    first_dut_d    = first_dut_q;
    first_scb_d    = first_scb_q;
    case (state_q)
      RUN: begin
        mask_d         = diff;
        mismatch_d     = |diff;
        sample_count_d = sample_count_q + 16'd1;
        if (|diff) begin
          // err_count is still zero exactly until the first mismatch of the run
          if (err_count_q == '0) begin
            first_idx_d = sample_count_q;
            first_dut_d = {dut_rco, dut_load, dut_Q};
            first_scb_d = {scb_rco, scb_load, scb_Q};
          end
          if (err_count_q != {ERRW{1'b1}}) err_count_d = err_count_q + ERRW'(1);
        end
        if (sample_count_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end
      end
      IDLE, DONE: begin
        mismatch_d = 1'b0;
        mask_d     = 3'b000;
        if (start) begin
          state_d        = RUN;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          err_count_d    = '0;
          sample_count_d = 16'd0;
          first_idx_d    = NO_ERR;
          first_dut_d    = 6'd0;
          first_scb_d    = 6'd0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      mismatch_q     <= 1'b0;
      mask_q         <= 3'b000;
      err_count_q    <= '0;
      sample_count_q <= 16'd0;
      first_idx_q    <= NO_ERR;
      first_dut_q    <= 6'd0;
      first_scb_q    <= 6'd0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      mismatch_q     <= mismatch_d;
      mask_q         <= mask_d;
      err_count_q    <= err_count_d;
      sample_count_q <= sample_count_d;
      first_idx_q    <= first_idx_d;
      first_dut_q    <= first_dut_d;
      first_scb_q    <= first_scb_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch      = mismatch_q;
  assign mismatch_mask = mask_q;
  assign err_count     = err_count_q;
  assign sample_count  = sample_count_q;
  assign first_err_idx = first_idx_q;
  assign first_err_dut = first_dut_q;
  assign first_err_scb = first_scb_q;

endmodule

// File: tb/tb_counter_result_checker.sv
// Randomised bench: a 100-sample and a 300-sample checker share one stimulus stream and
// are compared every cycle against a window-level model, plus literal checks of known scenarios.
module tb_counter_result_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [3:0] dQ = 4'd0, sQ = 4'd0;
  logic dL = 1'b0, dR = 1'b0, sL = 1'b0, sR = 1'b0;

  logic s_busy, s_done, s_pass, s_mm;
  logic [2:0] s_mask;
  logic [7:0] s_err;
  logic [15:0] s_sc, s_fidx;
  logic [5:0] s_fdut, s_fscb;
  logic l_busy, l_done, l_pass, l_mm;
  logic [2:0] l_mask;
  logic [7:0] l_err;
  logic [15:0] l_sc, l_fidx;
  logic [5:0] l_fdut, l_fscb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_result_checker #(.ITERATIONS(100), .ERRW(8)) u_short (
    .clk(clk), .reset(reset), .start(start),
    .dut_Q(dQ), .dut_load(dL), .dut_rco(dR),
    .scb_Q(sQ), .scb_load(sL), .scb_rco(sR),
    .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mm), .mismatch_mask(s_mask),
    .err_count(s_err), .sample_count(s_sc), .first_err_idx(s_fidx),
    .first_err_dut(s_fdut), .first_err_scb(s_fscb));

  counter_result_checker #(.ITERATIONS(300), .ERRW(8)) u_long (
    .clk(clk), .reset(reset), .start(start),
    .dut_Q(dQ), .dut_load(dL), .dut_rco(dR),
    .scb_Q(sQ), .scb_load(sL), .scb_rco(sR),
    .busy(l_busy), .done(l_done), .pass(l_pass), .mismatch(l_mm), .mismatch_mask(l_mask),
    .err_count(l_err), .sample_count(l_sc), .first_err_idx(l_fidx),
    .first_err_dut(l_fdut), .first_err_scb(l_fscb));

  // Window-level model: per checker, whether a window is open, how many samples it has
  // seen, the unsaturated error total and the first failing sample.
  int         win_len [2] = '{100, 300};
  bit         m_run   [2];
  bit         m_done  [2];
  int         m_n     [2];
  int         m_errs  [2];
  int         m_fidx  [2];
  logic [5:0] m_fdut  [2];
  logic [5:0] m_fscb  [2];
  logic [2:0] m_last  [2];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_run[i] = 0; m_done[i] = 0; m_n[i] = 0; m_errs[i] = 0;
        m_fidx[i] = 'hFFFF; m_fdut[i] = 6'd0; m_fscb[i] = 6'd0; m_last[i] = 3'b000;
      end else if (m_run[i]) begin
        m_last[i] = {dR != sR, dL != sL, dQ != sQ};
        if (m_last[i] != 3'b000) begin
          if (m_errs[i] == 0) begin
            m_fidx[i] = m_n[i];
            m_fdut[i] = {dR, dL, dQ};
            m_fscb[i] = {sR, sL, sQ};
          end
          m_errs[i]++;
        end
        m_n[i]++;
        if (m_n[i] == win_len[i]) begin
          m_run[i] = 0;
          m_done[i] = 1;
        end
      end else begin
        m_last[i] = 3'b000;
        if (start) begin
          m_run[i] = 1; m_done[i] = 0; m_n[i] = 0; m_errs[i] = 0;
          m_fidx[i] = 'hFFFF; m_fdut[i] = 6'd0; m_fscb[i] = 6'd0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic busy, input logic done, input logic pass,
                          input logic mm, input logic [2:0] mask, input logic [7:0] err,
                          input logic [15:0] sc, input logic [15:0] fidx,
                          input logic [5:0] fdut, input logic [5:0] fscb);
    string p;
    p = (i == 0) ? "short" : "long";
    chk({p, ".busy"}, 32'(busy), 32'(m_run[i]));
    chk({p, ".done"}, 32'(done), 32'(m_done[i]));
    chk({p, ".pass"}, 32'(pass), 32'(m_done[i] && m_errs[i] == 0));
    chk({p, ".mismatch"}, 32'(mm), 32'(m_last[i] != 3'b000));
    chk({p, ".mask"}, 32'(mask), 32'(m_last[i]));
    chk({p, ".err_count"}, 32'(err), (m_errs[i] > 255) ? 32'd255 : 32'(m_errs[i]));
    chk({p, ".sample_count"}, 32'(sc), 32'(m_n[i]));
    chk({p, ".first_err_idx"}, 32'(fidx), 32'(m_fidx[i]));
    chk({p, ".first_err_dut"}, 32'(fdut), 32'(m_fdut[i]));
    chk({p, ".first_err_scb"}, 32'(fscb), 32'(m_fscb[i]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, s_busy, s_done, s_pass, s_mm, s_mask, s_err, s_sc, s_fidx, s_fdut, s_fscb);
    cmp_inst(1, l_busy, l_done, l_pass, l_mm, l_mask, l_err, l_sc, l_fidx, l_fdut, l_fscb);
  end

  // mode 0 clean, 1 Q error at 37, 2 rco@10 + load@20, 3 Q always off by one, 4 random faults
  task automatic set_inputs(input int mode, input int j);
    sQ = 4'($urandom); sL = 1'($urandom); sR = 1'($urandom);
    dQ = sQ; dL = sL; dR = sR;
    case (mode)
      1: if (j == 37) begin sQ = 4'd4; dQ = 4'd5; sL = 0; dL = 0; sR = 0; dR = 0; end
      2: begin
        if (j == 10) dR = ~sR;
        if (j == 20) dL = ~sL;
      end
      3: dQ = sQ + 4'd1;
      4: begin
        if ($urandom_range(0, 7) == 0) dQ = sQ ^ 4'($urandom_range(1, 15));
        if ($urandom_range(0, 11) == 0) dL = ~sL;
        if ($urandom_range(0, 11) == 0) dR = ~sR;
      end
      default: ;
    endcase
  endtask

  task automatic run_window(input int n, input int mode, input int inj_start);
    @(negedge clk);
    set_inputs(0, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      set_inputs(mode, j);
      start = (j == inj_start);
      @(negedge clk);
      if (mode == 1 && j == 37) chk("mm_q37", {28'd0, s_mm, s_mask}, 32'b1001);
      if (mode == 2 && j == 10) chk("mm_rco10", {28'd0, s_mm, s_mask}, 32'b1100);
      if (mode == 2 && j == 20) chk("mm_load20", {28'd0, s_mm, s_mask}, 32'b1010);
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_vals;
    chk("rst.busy", 32'(s_busy), 0);
    chk("rst.done", 32'(s_done), 0);
    chk("rst.pass", 32'(s_pass), 0);
    chk("rst.mismatch", {28'd0, s_mm, s_mask}, 0);
    chk("rst.err_count", 32'(s_err), 0);
    chk("rst.sample_count", 32'(s_sc), 0);
    chk("rst.first_err_idx", 32'(s_fidx), 32'hFFFF);
    chk("rst.first_err", {20'd0, s_fdut, s_fscb}, 0);
    chk("rst.long_busy", 32'(l_busy), 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    // Saturation: 300 all-failing samples; the short window sees 100 of them
    run_window(300, 3, -1);
    chk("sat.long_done", 32'(l_done), 1);
    chk("sat.long_err", 32'(l_err), 255);
    chk("sat.long_sc", 32'(l_sc), 300);
    chk("sat.long_fidx", 32'(l_fidx), 0);
    chk("sat.short_err", 32'(s_err), 100);

    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;

    run_window(100, 0, -1);
    chk("clean.done", 32'(s_done), 1);
    chk("clean.pass", 32'(s_pass), 1);
    chk("clean.sc", 32'(s_sc), 100);
    chk("clean.fidx", 32'(s_fidx), 32'hFFFF);

    // Restart from DONE; the long checker is mid-run and must ignore it
    run_window(100, 1, -1);
    chk("q37.err", 32'(s_err), 1);
    chk("q37.fidx", 32'(s_fidx), 37);
    chk("q37.fdut", 32'(s_fdut), 32'h05);
    chk("q37.fscb", 32'(s_fscb), 32'h04);
    chk("q37.pass", {30'd0, s_done, s_pass}, 32'b10);

    run_window(100, 2, -1);
    chk("two.err", 32'(s_err), 2);
    chk("two.fidx", 32'(s_fidx), 10);

    run_window(100, 0, 30);
    chk("ign.done", 32'(s_done), 1);
    chk("ign.sc", 32'(s_sc), 100);

    // Asynchronous reset in the middle of a sample window
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 50; j++) begin
      set_inputs(4, j);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk); reset = 1'b0;
    run_window(100, 0, -1);
    chk("after_rst.pass", 32'(s_pass), 1);
    chk("after_rst.sc", 32'(s_sc), 100);

    for (int r = 0; r < 6; r++) begin
      int gap, inj;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        set_inputs(4, -1);
        @(negedge clk);
      end
      inj = $urandom_range(0, 160);
      run_window(100, 4, (inj < 100) ? inj : -1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_result_checker.md
# counter_result_checker

Synthesizable comparison engine for the 4-bit counter verification environment, at the receiving end of the stimulus path. The driver feeds identical stimulus to the counter under test and to the scoreboard. This block consumes both result streams (Q, load, rco), compares them every clock over a fixed window of ITERATIONS samples, and reports pass/fail, error count and the first failing sample. It replaces ad-hoc compare loops in the bench with a cycle-exact, reusable checker.

## Interface
- ITERATIONS, 100, number of samples compared per run; legal range 1..65535
- ERRW, 8, width of the saturating error counter
- clk  in  1  rising-edge clock, shared with driver, DUT and scoreboard
- reset  in  1  asynchronous, active-high; returns the block to IDLE
- start  in  1  single-cycle request to begin a check window
- dut_Q  in  4  counter-under-test value
- dut_load  in  1  counter-under-test load indicator
- dut_rco  in  1  counter-under-test ripple-carry-out
- scb_Q  in  4  scoreboard expected value
- scb_load  in  1  scoreboard expected load
- scb_rco  in  1  scoreboard expected rco
- busy  out  1  high while in RUN
- done  out  1  high in DONE
- pass  out  1  high in DONE only when err_count == 0
- mismatch  out  1  registered; high for the cycle after a differing sample
- mismatch_mask  out  3  registered per-field mismatch: [2]=rco, [1]=load, [0]=Q
- err_count  out  ERRW  mismatching samples this run; saturates at all-ones
- sample_count  out  16  samples taken this run
- first_err_idx  out  16  index (0-based) of the first mismatching sample; 16'hFFFF if none
- first_err_dut  out  6  {rco,load,Q} from the DUT at the first mismatch
- first_err_scb  out  6  {rco,load,Q} from the scoreboard at the first mismatch

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 at the edge, clear all counters and capture registers and go to RUN.
- RUN: busy=1. Each edge samples both streams.
  - Result = any bit differs across Q, load or rco.
  - sample_count increments by 1.
  - mismatch and mismatch_mask load the compare result.
  - On a mismatch, err_count increments and saturates at 2^ERRW-1.
  - On the first mismatch only, capture first_err_idx = current sample_count (pre-increment), first_err_dut and first_err_scb.
  - Go to DONE on the edge that takes sample ITERATIONS-1.
  - start is ignored in RUN.
- DONE: done=1, busy=0.
  - pass = (err_count == 0).
  - mismatch and mismatch_mask clear to 0.
  - All counters and capture registers hold.
  - start=1 clears and re-enters RUN; there is no pass through IDLE.
- pass is 0 in every state except DONE.
- A mismatch on the final sample is counted before done asserts.
- Comparison is exact bit equality. X or Z on inputs is not filtered; the bench must release reset on the DUT and scoreboard before pulsing start.

## Timing
- Reset values: busy=0, done=0, pass=0, mismatch=0, mismatch_mask=0, err_count=0, sample_count=0, first_err_idx=16'hFFFF, first_err_dut=0, first_err_scb=0, state=IDLE.
- Asserting reset clears every output immediately, without waiting for a clock edge, in any state.
- A run in progress when reset asserts is aborted and not resumed.
- start seen at edge k: samples are taken at edges k+1 .. k+ITERATIONS.
- busy rises after edge k.
- done and pass are valid after edge k+ITERATIONS; total latency is ITERATIONS+1 edges from start.
- mismatch and mismatch_mask reflect the sample taken at the immediately preceding edge (1-cycle latency).
- sample_count equals ITERATIONS while in DONE.
- With ITERATIONS=1, RUN lasts exactly one edge.

## Test plan
- Identical streams, ITERATIONS=100, start at edge 0 -> done after edge 100; pass=1, err_count=0, sample_count=100, first_err_idx=16'hFFFF, mismatch never high.
- Force dut_Q=5 while scb_Q=4 at sample 37 only -> mismatch=1 and mask=3'b001 for one cycle; err_count=1; first_err_idx=37; first_err_dut=6'h05; first_err_scb=6'h04; pass=0 in DONE.
- Flip dut_rco at sample 10 and dut_load at sample 20 -> err_count=2, first_err_idx=10, mask=3'b100 then 3'b010, first capture unchanged by the second error.
- ITERATIONS=300, dut_Q always scb_Q+1 -> err_count saturates at 255 and stays; sample_count=300; first_err_idx=0.
- Assert reset at sample 50 of a run -> all outputs at reset values without waiting for a clock edge; a new start afterwards runs a full clean 100-sample window with pass=1.
- Pulse start at sample 30 of a run -> ignored, run ends at sample 99. Pulse start in DONE -> counters clear and RUN restarts on the next edge.
